instr_fetch_unit: RTL

//   Fetch stage feeding the control state machine: holds the program counter, drives the instruction
//   ROM address and captures the 16-bit instruction into the instruction register (IRout). Obeys

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_pc_counter.sv | 31 +++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode encoding and the legal-opcode test
// used by the fetch stage and the control state machine.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    localparam logic [OPC_W-1:0] OP_MAX = OP_HALT;

    function automatic logic opc_illegal(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W] > OP_MAX;
    endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter: synchronous clear, gated increment, and a one-cycle pulse
// registered on the edge where the count rolls over from all-ones to zero.
module fetch_pc_counter #(
    parameter int ADDR_W = 7
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              clr,
    input  logic              en,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              wrap
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (en && inc) begin
            count <= count + 1'b1;
            wrap  <= &count;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM-latency ready tracking and the instruction register.
// Optional opcode legality flag is built only when ILLEGAL_OP_DET_EN is defined.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int ROM_LAT = 1
) (
    input  logic               Clk,
    input  logic               ResetN,
    input  logic               PCclr,
    input  logic               PCup,
    input  logic               IR_Id,
    input  logic [INSTR_W-1:0] InstrData,
    output logic [ADDR_W-1:0]  PCaddr,
    output logic [INSTR_W-1:0] IRout,
    output logic               IRvalid,
    output logic               PCwrap,
    output logic               FetchErr,
    output logic               IllegalOp
);

    localparam logic [0:0] ST_WAIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [1:0] LAT_INIT = ROM_LAT[1:0];
    localparam logic [0:0] ST_INIT  = (ROM_LAT == 0) ? ST_READY : ST_WAIT;

    logic [0:0]         state;
    logic [1:0]         lat_cnt;
    logic               ready;
    logic               blocked;
    logic               pc_change;
    logic [INSTR_W-1:0] ir_next;
    logic               irv_next;
    logic               ferr_next;

    assign ready     = (ROM_LAT == 0) ? 1'b1 : (state == ST_READY);
    // An underrun holds the PC so the retried fetch reads the same word.
    assign blocked   = IR_Id && !ready;
    assign pc_change = PCclr || (PCup && !blocked);

    fetch_pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .Clk    (Clk),
        .ResetN (ResetN),
        .clr    (PCclr),
        .en     (!blocked),
        .inc    (PCup),
        .count  (PCaddr),
        .wrap   (PCwrap)
    );

    always_ff @(posedge Clk) begin
        if (!ResetN || pc_change) begin
            state   <= ST_INIT;
            lat_cnt <= LAT_INIT;
        end else if (state == ST_WAIT) begin
            lat_cnt <= (lat_cnt == 2'd0) ? 2'd0 : lat_cnt - 2'd1;
            if (lat_cnt <= 2'd1) state <= ST_READY;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        ir_next   = IRout;
        irv_next  = IRvalid;
        ferr_next = FetchErr;
        if (PCclr) begin
            irv_next = 1'b0;
        end else if (IR_Id) begin
            if (ready) begin
                ir_next  = InstrData;
                irv_next = 1'b1;
            end else begin
                irv_next  = 1'b0;
                ferr_next = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            IRout    <= '0;
            IRvalid  <= 1'b0;
            FetchErr <= 1'b0;
        end else begin
            IRout    <= ir_next;
            IRvalid  <= irv_next;
            FetchErr <= ferr_next;
        end
    end

`ifdef ILLEGAL_OP_DET_EN
    always_ff @(posedge Clk) begin
        if (!ResetN || PCclr) IllegalOp <= 1'b0;
        else                  IllegalOp <= irv_next && opc_illegal(ir_next);
    end
`else
    assign IllegalOp = 1'b0;
`endif

endmodule
